time_frame_gen: RTL and testbench

TIME_FRAME_GEN -- requirements
Module: time_frame_gen

---
 rtl/time_frame_pkg.sv | 44 ++++
 rtl/time_counter.sv | 43 ++++
 rtl/time_frame_gen.sv | 101 ++++++++++
 tb/tb_time_frame_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/time_frame_pkg.sv
// ============================================================================
// Module  : time_frame_pkg
// Brief   : Shared frame layout, time limits and check-byte helper for the
//           time frame generator.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package time_frame_pkg;

    localparam int FIELD_W  = 8;
    localparam int FRAME_W  = 40;

    localparam int HDR_LSB  = 32;
    localparam int HOUR_LSB = 24;
    localparam int MIN_LSB  = 16;
    localparam int SEC_LSB  = 8;
    localparam int CHK_LSB  = 0;

    localparam logic [FIELD_W-1:0] HEADER_DEFAULT = 8'hA5;
    localparam logic [FIELD_W-1:0] HOUR_MAX       = 8'd23;
    localparam logic [FIELD_W-1:0] MIN_SEC_MAX    = 8'd59;

    typedef logic [FIELD_W-1:0] field_t;

    typedef struct packed {
        field_t hour;
        field_t minute;
        field_t second;
    } hms_t;

    // Modulo-256 sum of header and the three time fields.
    function automatic field_t calc_check(input field_t hdr, input hms_t t);
        return hdr + t.hour + t.minute + t.second;
    endfunction

    function automatic logic hms_in_range(input hms_t t);
        return (t.hour <= HOUR_MAX) && (t.minute <= MIN_SEC_MAX) &&
               (t.second <= MIN_SEC_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/time_counter.sv
// ============================================================================
// Module  : time_counter
// Brief   : Hour/minute/second cascade with synchronous load and midnight wrap.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_counter
    import time_frame_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic load,
    input  hms_t load_time,
    output hms_t time_now
);

    // Load takes priority so a set coincident with a second boundary wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_now <= '0;
        end else if (load) begin
            time_now <= load_time;
        end else if (inc) begin
            if (time_now.second == MIN_SEC_MAX) begin
                time_now.second <= '0;
                if (time_now.minute == MIN_SEC_MAX) begin
                    time_now.minute <= '0;
                    time_now.hour   <= (time_now.hour == HOUR_MAX) ? '0
                                                                   : time_now.hour + 8'd1;
                end else begin
                    time_now.minute <= time_now.minute + 8'd1;
                end
            end else begin
                time_now.second <= time_now.second + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/time_frame_gen.sv
// ============================================================================
// Module  : time_frame_gen
// Brief   : 1 s time-of-day frame generator with valid/ready output and
//           overrun flag. Macro TIME_FRAME_CKSUM_EN enables the check byte.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_frame_gen
    import time_frame_pkg::*;
#(
    parameter logic [25:0]        CNT_1S_MAX = 26'd49_999_999,
    parameter logic [FIELD_W-1:0] HEADER     = HEADER_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               set_en,
    input  logic [7:0]         set_h,
    input  logic [7:0]         set_m,
    input  logic [7:0]         set_s,
    input  logic               frame_ready,
    output logic               frame_valid,
    output logic [FRAME_W-1:0] dat_o,
    output logic               tick_1s,
    output logic               overrun
);

    logic [25:0]        presc;
    logic               terminal;
    logic               set_ok;
    logic               inc;
    logic               set_pending;
    logic               frame_load;
    hms_t               set_time;
    hms_t               now;
    field_t             check;
    logic [FRAME_W-1:0] frame_next;

    assign set_time   = {set_h, set_m, set_s};
    assign set_ok     = set_en && hms_in_range(set_time);
    assign terminal   = (presc == CNT_1S_MAX);
    assign inc        = terminal && !set_ok;
    assign frame_load = tick_1s || set_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            tick_1s     <= 1'b0;
            set_pending <= 1'b0;
        end else begin
            presc       <= (set_ok || terminal) ? '0 : presc + 26'd1;
            tick_1s     <= inc;
            set_pending <= set_ok;
        end
    end

    time_counter u_time_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc),
        .load      (set_ok),
        .load_time (set_time),
        .time_now  (now)
    );

`ifdef TIME_FRAME_CKSUM_EN
    assign check = calc_check(HEADER, now);
`else
    assign check = '0;
`endif

    always_comb begin
        frame_next                        = '0;
        frame_next[HDR_LSB  +: FIELD_W]   = HEADER;
        frame_next[HOUR_LSB +: FIELD_W]   = now.hour;
        frame_next[MIN_LSB  +: FIELD_W]   = now.minute;
        frame_next[SEC_LSB  +: FIELD_W]   = now.second;
        frame_next[CHK_LSB  +: FIELD_W]   = check;
    end

    // A load on the accepting edge replaces the consumed frame without overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_o       <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_load) begin
                dat_o       <= frame_next;
                frame_valid <= 1'b1;
                overrun     <= frame_valid && !frame_ready;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_time_frame_gen.sv
// ============================================================================
// Module  : tb_time_frame_gen
// Brief   : Directed self-checking bench for time_frame_gen (CNT_1S_MAX = 9).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_time_frame_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        set_en;
    logic [7:0]  set_h, set_m, set_s;
    logic        frame_ready;
    logic        frame_valid;
    logic [39:0] dat_o;
    logic        tick_1s;
    logic        overrun;

    int vec_count   = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] h, m, s;
        logic       accept;
    } set_vec_t;

    set_vec_t vecs[8];

    time_frame_gen #(
        .CNT_1S_MAX (26'd9),
        .HEADER     (8'hA5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_en      (set_en),
        .set_h       (set_h),
        .set_m       (set_m),
        .set_s       (set_s),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .dat_o       (dat_o),
        .tick_1s     (tick_1s),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] fr(input logic [7:0] h, input logic [7:0] m,
                                       input logic [7:0] s);
        logic [7:0] c;
`ifdef TIME_FRAME_CKSUM_EN
        c = 8'hA5 + h + m + s;
`else
        c = 8'h00;
`endif
        return {8'hA5, h, m, s, c};
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        set_en = 1'b1;
        set_h  = h;
        set_m  = m;
        set_s  = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'd12,  8'd34,  8'd56,  1'b1};
        vecs[1] = '{8'd1,   8'd60,  8'd0,   1'b0};
        vecs[2] = '{8'd0,   8'd0,   8'd0,   1'b1};
        vecs[3] = '{8'd24,  8'd0,   8'd0,   1'b0};
        vecs[4] = '{8'd23,  8'd59,  8'd59,  1'b1};
        vecs[5] = '{8'd0,   8'd0,   8'd60,  1'b0};
        vecs[6] = '{8'd9,   8'd8,   8'd7,   1'b1};
        vecs[7] = '{8'd255, 8'd255, 8'd255, 1'b0};

        rst_n = 1'b0; set_en = 1'b0; set_h = '0; set_m = '0; set_s = '0;
        frame_ready = 1'b1;
        step(2);
        chk("rst_valid",   {39'd0, frame_valid}, 40'd0);
        chk("rst_dat",     dat_o,                40'd0);
        chk("rst_tick",    {39'd0, tick_1s},     40'd0);
        chk("rst_overrun", {39'd0, overrun},     40'd0);

        // First frame after reset release: tick after edge 10, frame after edge 11.
        rst_n = 1'b1;
        step(10);
        chk("first_tick",  {39'd0, tick_1s},     40'd1);
        chk("first_pre",   {39'd0, frame_valid}, 40'd0);
        step();
        chk("first_valid", {39'd0, frame_valid}, 40'd1);
        chk("first_dat",   dat_o,                fr(8'd0, 8'd0, 8'd1));
        step();
        chk("first_drop",  {39'd0, frame_valid}, 40'd0);

        // Back-pressure: ready low, overrun on 2nd and 3rd frames.
        rst_n = 1'b0; frame_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step(11);
        chk("bp_valid1",   {39'd0, frame_valid}, 40'd1);
        chk("bp_dat1",     dat_o,                fr(8'd0, 8'd0, 8'd1));
        chk("bp_ovr1",     {39'd0, overrun},     40'd0);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("bp_hold_valid", {39'd0, frame_valid}, 40'd1);
            chk("bp_hold_dat",   dat_o,                fr(8'd0, 8'd0, 8'd1));
        end
        step();
        chk("bp_dat2",     dat_o,                fr(8'd0, 8'd0, 8'd2));
        chk("bp_ovr2",     {39'd0, overrun},     40'd1);
        step();
        chk("bp_ovr_pulse", {39'd0, overrun},    40'd0);
        step(9);
        chk("bp_dat3",     dat_o,                fr(8'd0, 8'd0, 8'd3));
        chk("bp_ovr3",     {39'd0, overrun},     40'd1);
        step(5);
        chk("bp_valid_end", {39'd0, frame_valid}, 40'd1);

        // Asynchronous reset mid-handshake.
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {39'd0, frame_valid}, 40'd0);
        chk("async_dat",   dat_o,                40'd0);
        step();
        rst_n = 1'b1; frame_ready = 1'b1;
        step(3);

        // Table of set requests, one every three edges.
        for (int i = 0; i < 8; i++) begin
            drive_set(vecs[i].h, vecs[i].m, vecs[i].s);
            step();
            set_en = 1'b0;
            chk("tbl_no_tick", {39'd0, tick_1s},     40'd0);
            chk("tbl_pre",     {39'd0, frame_valid}, 40'd0);
            step();
            chk("tbl_valid",   {39'd0, frame_valid}, {39'd0, vecs[i].accept});
            if (vecs[i].accept)
                chk("tbl_dat", dat_o, fr(vecs[i].h, vecs[i].m, vecs[i].s));
            step();
        end

        // Midnight rollover with an ignored set in between.
        drive_set(8'd23, 8'd59, 8'd58);
        step();
        set_en = 1'b0;
        chk("mn_no_tick0", {39'd0, tick_1s},     40'd0);
        step();
        chk("mn_dat0",     dat_o,                fr(8'd23, 8'd59, 8'd58));
        chk("mn_valid0",   {39'd0, frame_valid}, 40'd1);
        chk("mn_no_tick1", {39'd0, tick_1s},     40'd0);
        step(2);
        drive_set(8'd1, 8'd60, 8'd0);
        step();
        set_en = 1'b0;
        step();
        chk("bad_no_frame", {39'd0, frame_valid}, 40'd0);
        step(5);
        chk("mn_tick1",    {39'd0, tick_1s},     40'd1);
        step();
        chk("mn_dat1",     dat_o,                fr(8'd23, 8'd59, 8'd59));
        chk("mn_ovr1",     {39'd0, overrun},     40'd0);
        step();
        chk("mn_drop1",    {39'd0, frame_valid}, 40'd0);
        step(8);
        chk("mn_tick2",    {39'd0, tick_1s},     40'd1);
        step();
        chk("mn_dat2",     dat_o,                fr(8'd0, 8'd0, 8'd0));
        chk("mn_valid2",   {39'd0, frame_valid}, 40'd1);

        // Set coincident with terminal count wins.
        step(8);
        drive_set(8'd5, 8'd6, 8'd7);
        step();
        set_en = 1'b0;
        chk("tc_no_tick",  {39'd0, tick_1s},     40'd0);
        step();
        chk("tc_dat",      dat_o,                fr(8'd5, 8'd6, 8'd7));
        chk("tc_valid",    {39'd0, frame_valid}, 40'd1);
        chk("tc_no_tick2", {39'd0, tick_1s},     40'd0);
        step(9);
        chk("tc_tick",     {39'd0, tick_1s},     40'd1);
        step();
        chk("tc_dat_next", dat_o,                fr(8'd5, 8'd6, 8'd8));
        chk("tc_valid_next", {39'd0, frame_valid}, 40'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
